// File: rtl/draw_player_rect.sv
// Player rectangle overlay for the VGA pixel pipeline.
// Position and endgame are latched once per frame; the sprite blinks after endgame.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

module draw_player_rect
  import vga_pkg::*;
#(
  parameter int          XPOS          = 64,
  parameter int          WIDTH         = 32,
  parameter int          HEIGHT        = 32,
  parameter logic [11:0] COLOR         = 12'hFF0,
  parameter logic [11:0] ENDGAME_COLOR = 12'hF00,
  parameter int          BLINK_FRAMES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] ypos,
  input  logic        endgame,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BLINK_FRAMES - 1);
  localparam logic [11:0] YMAX = 12'(VER_PIXELS - HEIGHT);
  localparam logic [11:0] X0 = 12'(XPOS);
  localparam logic [11:0] X1 = 12'(XPOS + WIDTH - 1);
  localparam logic [11:0] YH = 12'(HEIGHT - 1);

  logic [10:0] r_vcount_s1;
  logic        r_vsync_s1;
  logic        r_vblnk_s1;
  logic [10:0] r_hcount_s1;
  logic        r_hsync_s1;
  logic        r_hblnk_s1;
  logic [11:0] r_rgb_s1;
  logic        r_hit_s1;
  logic [11:0] r_ypos_frame;
  logic        r_endgame_frame;
  logic [CW-1:0] r_cnt;
  logic        r_phase;

  logic        w_strobe;
  logic [11:0] w_ypos_clamp;
  logic [11:0] w_hc;
  logic [11:0] w_vc;
  logic [11:0] w_y1;
  logic        w_hit;
  logic [11:0] w_rgb;

  assign w_strobe     = vblnk_in & ~r_vblnk_s1;
  assign w_ypos_clamp = (ypos > YMAX) ? YMAX : ypos;
  assign w_hc         = {1'b0, hcount_in};
  assign w_vc         = {1'b0, vcount_in};
  assign w_y1         = r_ypos_frame + YH;

  assign w_hit = !hblnk_in && !vblnk_in &&
                 (w_hc >= X0) && (w_hc <= X1) &&
                 (w_vc >= r_ypos_frame) && (w_vc <= w_y1);

  // Hidden blink phase lets the background show through the sprite.
  always_comb begin
    w_rgb = r_rgb_s1;
    if (r_hit_s1) begin
      if (!r_endgame_frame)
        w_rgb = COLOR;
      else if (!r_phase)
        w_rgb = ENDGAME_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vcount_s1     <= '0;
      r_vsync_s1      <= 1'b0;
      r_vblnk_s1      <= 1'b0;
      r_hcount_s1     <= '0;
      r_hsync_s1      <= 1'b0;
      r_hblnk_s1      <= 1'b0;
      r_rgb_s1        <= '0;
      r_hit_s1        <= 1'b0;
      vcount_out      <= '0;
      vsync_out       <= 1'b0;
      vblnk_out       <= 1'b0;
      hcount_out      <= '0;
      hsync_out       <= 1'b0;
      hblnk_out       <= 1'b0;
      rgb_out         <= '0;
      r_ypos_frame    <= '0;
      r_endgame_frame <= 1'b0;
      r_cnt           <= '0;
      r_phase         <= 1'b0;
    end else begin
      r_vcount_s1 <= vcount_in;
      r_vsync_s1  <= vsync_in;
      r_vblnk_s1  <= vblnk_in;
      r_hcount_s1 <= hcount_in;
      r_hsync_s1  <= hsync_in;
      r_hblnk_s1  <= hblnk_in;
      r_rgb_s1    <= rgb_in;
      r_hit_s1    <= w_hit;
      vcount_out  <= r_vcount_s1;
      vsync_out   <= r_vsync_s1;
      vblnk_out   <= r_vblnk_s1;
      hcount_out  <= r_hcount_s1;
      hsync_out   <= r_hsync_s1;
      hblnk_out   <= r_hblnk_s1;
      rgb_out     <= w_rgb;
      if (w_strobe) begin
        r_ypos_frame    <= w_ypos_clamp;
        r_endgame_frame <= endgame;
      end
      if (!r_endgame_frame) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (w_strobe) begin
        if (r_cnt == CMAX) begin
          r_cnt   <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_player_rect.sv
// Randomized bench for draw_player_rect with a frame-level reference model.
// Every cycle compares rgb and delayed timing against the model.
module tb_draw_player_rect;

  localparam int XP = 64;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int VP = 600;
  localparam int BL = 32;
  localparam logic [11:0] COL = 12'hFF0;
  localparam logic [11:0] EGC = 12'hF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0] rgb_in, ypos;
  logic        endgame;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;

  draw_player_rect dut (
    .clk(clk), .rst(rst),
    .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .hcount_in(hcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in), .ypos(ypos), .endgame(endgame),
    .vcount_out(vcount_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .hcount_out(hcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [25:0] tim;
    logic [11:0] rgb;
    bit          hit;
  } rec_t;

  rec_t s1;
  int   m_yf, m_frames;
  bit   m_ef, m_pvb;
  logic [25:0] e_tim;
  logic [11:0] e_rgb;

  task automatic tick();
    rec_t cur;
    bit   hidden;
    @(posedge clk);
    if (rst) begin
      s1 = '{tim: '0, rgb: '0, hit: 1'b0};
      e_tim = '0; e_rgb = '0;
      m_yf = 0; m_frames = 0; m_ef = 0; m_pvb = 0;
    end else begin
      cur.tim = {vcount_in, vsync_in, vblnk_in,
                 hcount_in, hsync_in, hblnk_in};
      cur.rgb = rgb_in;
      cur.hit = !hblnk_in && !vblnk_in &&
                int'(hcount_in) >= XP && int'(hcount_in) < XP + W &&
                int'(vcount_in) >= m_yf && int'(vcount_in) < m_yf + H;
      hidden = ((m_frames / BL) % 2) == 1;
      e_tim = s1.tim;
      if (!s1.hit) e_rgb = s1.rgb;
      else if (!m_ef) e_rgb = COL;
      else e_rgb = hidden ? s1.rgb : EGC;
      s1 = cur;
      if (vblnk_in && !m_pvb) begin
        m_frames = m_ef ? m_frames + 1 : 0;
        m_ef = endgame;
        m_yf = (int'(ypos) > VP - H) ? VP - H : int'(ypos);
      end
      m_pvb = vblnk_in;
    end
    #1;
    check("rgb", {20'd0, rgb_out}, {20'd0, e_rgb});
    check("timing", {6'd0, vcount_out, vsync_out, vblnk_out,
                     hcount_out, hsync_out, hblnk_out}, {6'd0, e_tim});
  endtask

  task automatic pix(input int h, input int v, input bit hb,
                     input logic [11:0] c);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    hsync_in  = 1'($urandom_range(0, 1));
    vsync_in  = 1'b0;
    rgb_in    = c;
    tick();
  endtask

  task automatic vbl();
    for (int i = 0; i < 2; i++) pix(900, VP - 1, 1'b1, 12'h00F);
    for (int i = 0; i < 3; i++) begin
      hcount_in = 11'(i);
      vcount_in = 11'(VP + 1);
      hblnk_in  = 1'b1;
      vblnk_in  = 1'b1;
      vsync_in  = 1'b1;
      rgb_in    = 12'h000;
      tick();
    end
  endtask

  task automatic rand_pix(input int n);
    int h, v;
    bit hb;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(0, 1) ? $urandom_range(XP - 8, XP + W + 8)
                               : $urandom_range(0, 1055);
      v = $urandom_range(0, 1) ? m_yf - 4 + $urandom_range(0, H + 8)
                               : $urandom_range(0, VP - 1);
      if (v < 0) v = 0;
      if (v > VP - 1) v = VP - 1;
      hb = (h >= 800) || ($urandom_range(0, 7) == 0);
      pix(h, v, hb, 12'($urandom));
    end
  endtask

  int hs[4] = '{XP - 1, XP, XP + W - 1, XP + W};

  initial begin
    rst = 1'b1; ypos = 12'd100; endgame = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 12'h00F;
    tick(); tick();
    check("reset_rgb", {20'd0, rgb_out}, 32'd0);
    rst = 1'b0;

    vbl();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        pix(hs[b], 99 + (a / 2) * 32 + (a % 2), 1'b0, 12'h00F);
    rand_pix(60);

    vbl();
    rand_pix(30);
    pix(XP, 300, 1'b0, 12'h00F);
    ypos = 12'd200;
    endgame = 1'b1;
    pix(XP + 1, 300, 1'b0, 12'h00F);
    endgame = 1'b0;
    pix(XP, 100, 1'b0, 12'h00F);
    pix(XP, 131, 1'b0, 12'h00F);
    pix(XP, 200, 1'b0, 12'h00F);
    rand_pix(30);
    vbl();
    pix(XP, 100, 1'b0, 12'h00F);
    pix(XP, 200, 1'b0, 12'h00F);
    pix(XP, 231, 1'b0, 12'h00F);
    pix(XP, 232, 1'b0, 12'h00F);
    rand_pix(40);

    ypos = 12'd590;
    vbl();
    pix(XP, 567, 1'b0, 12'h00F);
    pix(XP, 568, 1'b0, 12'h00F);
    pix(XP, 599, 1'b0, 12'h00F);
    pix(XP, 0, 1'b0, 12'h00F);
    pix(XP, 21, 1'b0, 12'h00F);
    rand_pix(40);

    ypos = 12'd0;
    vbl();
    pix(XP, 0, 1'b0, 12'h00F);
    pix(XP + W - 1, H - 1, 1'b0, 12'h00F);
    pix(XP + 2, 5, 1'b1, 12'h0A5);

    ypos = 12'd50;
    endgame = 1'b1;
    for (int f = 0; f < 70; f++) begin
      vbl();
      pix(XP + 3, 50, 1'b0, 12'($urandom));
      pix(XP + 10, 81, 1'b0, 12'($urandom));
      pix(XP + 5, 60, 1'b1, 12'($urandom));
      rand_pix(6);
    end

    pix(XP, 55, 1'b0, 12'h00F);
    rst = 1'b1;
    pix(XP, 56, 1'b0, 12'h00F);
    rst = 1'b0;
    check("rst_rgb", {20'd0, rgb_out}, 32'd0);
    check("rst_tim", {6'd0, vcount_out, vsync_out, vblnk_out,
                      hcount_out, hsync_out, hblnk_out}, 32'd0);
    ypos = 12'd300;
    pix(XP, 0, 1'b0, 12'h00F);
    pix(XP, 31, 1'b0, 12'h00F);
    pix(XP, 32, 1'b0, 12'h00F);
    pix(XP, 300, 1'b0, 12'h00F);
    pix(900, 0, 1'b1, 12'h00F);
    pix(900, 0, 1'b1, 12'h00F);
    vbl();
    pix(XP, 0, 1'b0, 12'h00F);
    pix(XP, 300, 1'b0, 12'h00F);
    rand_pix(30);
    endgame = 1'b0;
    vbl();
    rand_pix(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_player_rect.md
Name: draw_player_rect

Overview:
- Downstream consumer of the player position controller; overlays the player rectangle onto the VGA pixel stream at fixed column XPOS and row ypos.
- Sits in the VGA drawing pipeline between the background drawer and the output register stage.
- Samples position and endgame once per frame so the sprite never tears mid-frame.
- After endgame, the sprite blinks in ENDGAME_COLOR.

Parameters:
XPOS, 64, left column of rectangle (pixels)
WIDTH, 32, rectangle width (pixels), >=1
HEIGHT, 32, rectangle height (pixels), >=1, < VER_PIXELS
COLOR, 12'hFF0, rectangle RGB444 colour in normal play
ENDGAME_COLOR, 12'hF00, rectangle colour after endgame
BLINK_FRAMES, 32, frames per blink half-period after endgame, >=1

Ports:
clk  input  1  pixel clock
rst  input  1  reset
vcount_in  input  11  vertical pixel counter
vsync_in  input  1  vertical sync
vblnk_in  input  1  vertical blank
hcount_in  input  11  horizontal pixel counter
hsync_in  input  1  horizontal sync
hblnk_in  input  1  horizontal blank
rgb_in  input  12  upstream pixel colour
ypos  input  12  rectangle top row from position controller
endgame  input  1  game-over flag from position controller
vcount_out  output  11  vcount_in delayed 2 cycles
vsync_out  output  1  vsync_in delayed 2 cycles
vblnk_out  output  1  vblnk_in delayed 2 cycles
hcount_out  output  11  hcount_in delayed 2 cycles
hsync_out  output  1  hsync_in delayed 2 cycles
hblnk_out  output  1  hblnk_in delayed 2 cycles
rgb_out  output  12  pixel colour with rectangle overlaid

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- On reset: all outputs 0, internal pipeline registers 0, ypos_frame 0, endgame_frame 0, blink counter 0, blink phase 0.
- Frame latch:
  - vblnk_in is registered; a rising edge (prev=0, cur=1) is the frame strobe.
  - On the strobe: ypos_frame <= min(ypos, VER_PIXELS-HEIGHT) using vga_pkg::VER_PIXELS, compared in 12 bits. endgame_frame <= endgame.
  - Between strobes, ypos and endgame changes are ignored.
- Blink counter (counts frame strobes):
  - Counts only while endgame_frame=1; held at 0 while endgame_frame=0.
  - Reaching BLINK_FRAMES-1 wraps the counter to 0 and toggles blink_phase.
  - blink_phase is forced to 0 while endgame_frame=0.
- Stage 1 (cycle n+1):
  - Register all timing inputs and rgb_in.
  - Compute hit = !hblnk_in && !vblnk_in && hcount_in in [XPOS, XPOS+WIDTH-1] && vcount_in in [ypos_frame, ypos_frame+HEIGHT-1].
  - Counters are zero-extended to 12 bits; bounds are 12-bit sums with no wrap.
- Stage 2 (cycle n+2):
  - Timing outputs = stage-1 values.
  - rgb_out = rgb_s1 if !hit_s1.
  - Otherwise COLOR if endgame_frame=0.
  - Otherwise ENDGAME_COLOR if blink_phase=0, else rgb_s1 (sprite hidden).
- Latency: exactly 2 clk for every output, with no bubbles and no stall.
- Boundaries:
  - ypos=0: top row drawn at vcount 0.
  - ypos > VER_PIXELS-HEIGHT: clamped so the bottom edge lands on VER_PIXELS-1.
  - XPOS+WIDTH > HOR_PIXELS: drawing is truncated naturally by hblnk.
- Simultaneous events:
  - ypos change in the same cycle as the strobe: the new value is latched.
  - endgame rising with the strobe: endgame_frame=1 from that frame; the blink counter starts next strobe.
- Reset mid-frame: outputs 0 next cycle; the rectangle reappears at row 0 until the first strobe after reset.

Test Plan:
1. Reset, then feed an 800x600 timing stream with ypos=100 and rgb_in=12'h00F. Required: rgb_out=12'hFF0 exactly for hcount 64..95 and vcount 100..131; 12'h00F elsewhere; all timing outputs equal the inputs delayed 2 clk.
2. Change ypos 100->200 mid-frame at vcount 300. Required: the current frame is still drawn at rows 100..131; the next frame at rows 200..231.
3. Set ypos=590 (above 600-32). Required: drawn at rows 568..599 with no wrap to top rows.
4. Assert endgame with ypos=50. Required: from the next frame the rectangle is 12'hF00 for 32 frames, then shows rgb_in for 32 frames, then 12'hF00 again.
5. Pixel inside the rectangle coordinates while hblnk_in=1. Required: rgb_out=rgb_in delayed, with no overlay.
6. Assert rst during a frame with endgame active. Required: all outputs 0 next cycle; after reset, the sprite is COLOR at row 0 until a vblank rising edge latches ypos.
